// File: rtl/block_compact_queue.sv
// Element-granular collapsing FIFO: appends 0..ELMS elements per cycle behind resident data and
// exposes the oldest ELMS elements as a left-aligned head window.
module block_compact_queue #(
  parameter int ELMS  = 8,
  parameter int DATA  = 8,
  parameter int DEPTH = 16,
  parameter int CNT   = $clog2(ELMS + 1),
  parameter int OCC   = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [CNT-1:0]                 in_num,
  input  logic [ELMS-1:0][DATA-1:0]      in_data,
  output logic                           in_ready,
  output logic [ELMS-1:0][DATA-1:0]      out_data,
  output logic [CNT-1:0]                 out_avail,
  input  logic [CNT-1:0]                 out_pop,
  output logic [OCC-1:0]                 count
);

  logic [DEPTH-1:0][DATA-1:0] mem_q, mem_d;
  logic [OCC-1:0]             count_q, count_d;

  logic [CNT-1:0]             pop_eff;
  logic [CNT-1:0]             push_eff;
  logic [OCC-1:0]             base;
  logic [DEPTH-1:0][DATA-1:0] mem_shift;
  logic [DEPTH-1:0][DATA-1:0] push_vec;

  assign in_ready  = (OCC'(DEPTH) - count_q) >= OCC'(ELMS);
  assign out_avail = (count_q >= OCC'(ELMS)) ? CNT'(ELMS) : CNT'(count_q);
  assign out_data  = mem_q[ELMS-1:0];
  assign count     = count_q;

  always_comb begin
    pop_eff  = (out_pop > out_avail) ? out_avail : out_pop;
    push_eff = '0;
    if (in_valid && in_ready) begin
      push_eff = (in_num > CNT'(ELMS)) ? CNT'(ELMS) : in_num;
    end

    base = count_q - OCC'(pop_eff);

    // Right shift of the packed store moves element k+pop_eff to k and zero-fills the top.
    mem_shift = mem_q >> (32'(pop_eff) * DATA);

    push_vec = '0;
    for (int j = 0; j < ELMS; j++) begin
      if (CNT'(j) < push_eff) begin
        push_vec[j] = in_data[j];
      end
    end

    // Slots at or above base are zero after the shift, so OR-ing places the new elements.
    mem_d   = mem_shift | (push_vec << (32'(base) * DATA));
    count_d = base + OCC'(push_eff);

    if (flush) begin
      mem_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_block_compact_queue.sv
// Directed and randomized checks of block_compact_queue against a queue-based reference model.
module tb_block_compact_queue;

  localparam int ELMS  = 8;
  localparam int DATA  = 8;
  localparam int DEPTH = 16;
  localparam int CNT   = $clog2(ELMS + 1);
  localparam int OCC   = $clog2(DEPTH + 1);

  logic                      clk      = 1'b0;
  logic                      reset_n  = 1'b0;
  logic                      flush    = 1'b0;
  logic                      in_valid = 1'b0;
  logic [CNT-1:0]            in_num   = '0;
  logic [ELMS-1:0][DATA-1:0] in_data  = '0;
  logic [CNT-1:0]            out_pop  = '0;
  logic                      in_ready;
  logic [ELMS-1:0][DATA-1:0] out_data;
  logic [CNT-1:0]            out_avail;
  logic [OCC-1:0]            count;

  int checks = 0;
  int errors = 0;
  logic [DATA-1:0] model_q[$];

  block_compact_queue #(.ELMS(ELMS), .DATA(DATA), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_num    (in_num),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_avail (out_avail),
    .out_pop   (out_pop),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [ELMS-1:0][DATA-1:0] exp_data;
    int sz;
    int av;
    sz = model_q.size();
    av = (sz < ELMS) ? sz : ELMS;
    exp_data = '0;
    for (int i = 0; i < ELMS; i++) begin
      if (i < sz) exp_data[i] = model_q[i];
    end
    check_eq({tag, " count"},     64'(count),     64'(sz));
    check_eq({tag, " out_avail"}, 64'(out_avail), 64'(av));
    check_eq({tag, " in_ready"},  64'(in_ready),  64'((DEPTH - sz) >= ELMS));
    check_eq({tag, " out_data"},  64'(out_data),  64'(exp_data));
    $display("%s: flush=%0b valid=%0b num=%0d pop=%0d -> count=%0d avail=%0d ready=%0b data=%h",
             tag, flush, in_valid, in_num, out_pop, count, out_avail, in_ready, out_data);
  endtask

  // Advance one clock: the model applies the rules to the inputs present at the edge.
  task automatic cycle(input string tag);
    int sz;
    int av;
    int pe;
    int pu;
    sz = model_q.size();
    av = (sz < ELMS) ? sz : ELMS;
    pe = (int'(out_pop) > av) ? av : int'(out_pop);
    pu = 0;
    if (in_valid && ((DEPTH - sz) >= ELMS)) pu = (int'(in_num) > ELMS) ? ELMS : int'(in_num);
    if (flush) begin
      model_q.delete();
    end else begin
      repeat (pe) void'(model_q.pop_front());
      for (int j = 0; j < pu; j++) model_q.push_back(in_data[j]);
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " count"},     64'(count),     64'd0);
    check_eq({tag, " out_avail"}, 64'(out_avail), 64'd0);
    check_eq({tag, " out_data"},  64'(out_data),  64'd0);
    check_eq({tag, " in_ready"},  64'(in_ready),  64'd1);
    $display("%s: count=%0d avail=%0d ready=%0b data=%h", tag, count, out_avail, in_ready, out_data);
  endtask

  initial begin
    // Test 1: reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    model_q.delete();
    @(negedge clk);
    reset_n = 1'b1;

    // Test 2: push 3 elements; unused input lanes carry junk that must be ignored
    in_data  = {8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'd3, 8'd2, 8'd1};
    in_valid = 1'b1;
    in_num   = CNT'(3);
    cycle("push3");
    check_eq("push3 const count", 64'(count),    64'd3);
    check_eq("push3 const data",  64'(out_data), 64'h0000000000030201);

    // Test 3: pop 2 while pushing 4
    in_data = {8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'd7, 8'd6, 8'd5, 8'd4};
    in_num  = CNT'(4);
    out_pop = CNT'(2);
    cycle("pop2push4");
    check_eq("pop2push4 const count", 64'(count),    64'd5);
    check_eq("pop2push4 const data",  64'(out_data), 64'h0000000706050403);

    // Test 4: full-window push, then a push refused while not ready
    in_data = {8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11};
    in_num  = CNT'(8);
    out_pop = '0;
    cycle("push8");
    check_eq("push8 const count", 64'(count),    64'd13);
    check_eq("push8 const ready", 64'(in_ready), 64'd0);
    check_eq("push8 const data",  64'(out_data), 64'h1312110706050403);
    in_num = CNT'(2);
    cycle("push_blocked");
    check_eq("push_blocked const count", 64'(count), 64'd13);

    // Test 5: oversized pops, second one clamped to the remaining 5
    in_valid = 1'b0;
    out_pop  = CNT'(8);
    cycle("pop8_a");
    check_eq("pop8_a const count", 64'(count), 64'd5);
    cycle("pop8_b");
    check_eq("pop8_b const count", 64'(count),    64'd0);
    check_eq("pop8_b const data",  64'(out_data), 64'd0);
    check_eq("pop8_b const ready", 64'(in_ready), 64'd1);

    // Pop on empty queue is a no-op
    cycle("pop_empty");

    // Test 6: flush beats a concurrent push
    out_pop  = '0;
    in_valid = 1'b1;
    in_num   = CNT'(6);
    in_data  = {8'hA8, 8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1};
    cycle("push6");
    check_eq("push6 const count", 64'(count), 64'd6);
    flush  = 1'b1;
    in_num = CNT'(4);
    cycle("flush_push");
    check_eq("flush_push const count", 64'(count), 64'd0);
    flush = 1'b0;

    // Full pop plus push: new data lands at index 0
    in_num = CNT'(5);
    cycle("refill");
    out_pop = CNT'(5);
    in_num  = CNT'(2);
    in_data = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB2, 8'hB1};
    cycle("fullpop_push");
    check_eq("fullpop_push const data", 64'(out_data), 64'h000000000000B2B1);

    // Asynchronous reset in the middle of a push
    out_pop = '0;
    in_num  = CNT'(5);
    cycle("pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_q.delete();
    in_valid = 1'b0;
    in_num   = '0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle("post_reset");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      flush    = ($urandom_range(0, 31) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_num   = CNT'($urandom_range(0, ELMS + 2));
      out_pop  = CNT'($urandom_range(0, ELMS + 2));
      in_data  = {$urandom, $urandom};
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
